ysyx_24110006_alu_arbiter: RTL

//  Shares one ysyx_24110006_ALU between two requesters: req0 = EXU (integer ops), req1 = LSU/BRU (address/compare).

---
 rtl/ysyx_24110006_alu_arbiter_if.sv | 45 ++++
 rtl/ysyx_24110006_alu_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_alu_arbiter_if
//   One requester channel of the shared-ALU arbiter: a request (operands and
//   op select) and the matching response (result, compare flag, raw sum).
//
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both high. The source of valid may drop it before the transfer
//   without committing anything. Once the arbiter raises rsp_valid, it holds
//   rsp_valid and the response data stable until rsp_ready is seen high.
//
//   Signals:
//     req_valid / req_ready   request handshake
//     req_a, req_b            operands (req_b already inverted for subtract)
//     req_sub, req_sign       carry-in, signed-compare select
//     req_alu_t               one-hot ALU op select (ALU_T_W bits)
//     rsp_valid / rsp_ready   response handshake
//     rsp_r, rsp_cmp, rsp_add_r   ALU result, compare flag, raw adder output
//   Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface ysyx_24110006_alu_arbiter_if #(
    parameter int ALU_T_W = 13
);
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_a;
    logic [31:0]        req_b;
    logic               req_sub;
    logic               req_sign;
    logic [ALU_T_W-1:0] req_alu_t;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_r;
    logic               rsp_cmp;
    logic [31:0]        rsp_add_r;

    modport master (
        output req_valid, req_a, req_b, req_sub, req_sign, req_alu_t, rsp_ready,
        input  req_ready, rsp_valid, rsp_r, rsp_cmp, rsp_add_r
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_sign, req_alu_t, rsp_ready,
        output req_ready, rsp_valid, rsp_r, rsp_cmp, rsp_add_r
    );
endinterface

// File: rtl/ysyx_24110006_alu_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_alu_arbiter
//   Shares one ALU between two requesters (req0 = EXU, req1 = LSU/BRU).
//   Round-robin arbitration in IDLE, operands latched on accept, the ALU is
//   driven from the latches for one EXEC cycle, the result is registered and
//   returned on the winner's response channel in RESP.
//
//   Ports:
//     i_clock, i_reset        clock, synchronous active-high reset
//     req0, req1              requester channels (slave modport)
//     o_alu_a/b/sub/sign/t    to the ALU inputs (always the latch registers)
//     i_alu_r/add_r/cmp       from the ALU outputs
//     o_state                 debug view of the FSM state (0 IDLE,1 EXEC,2 RESP)
//     o_grant0_cnt, o_grant1_cnt, o_conflict_cnt
//                             perf counters, present only with ALU_ARB_PERF_EN
//   Parameters: ALU_T_W (op-select width, default `ALU_TYPE),
//               CNT_W (counter width, exists only with ALU_ARB_PERF_EN).
//   Optional feature macro: ALU_ARB_PERF_EN.
// ----------------------------------------------------------------------------
`ifndef ALU_TYPE
`define ALU_TYPE 13
`endif

module ysyx_24110006_alu_arbiter #(
    parameter int ALU_T_W = `ALU_TYPE
`ifdef ALU_ARB_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    ysyx_24110006_alu_arbiter_if.slave  req0,
    ysyx_24110006_alu_arbiter_if.slave  req1,
    output logic [31:0]                 o_alu_a,
    output logic [31:0]                 o_alu_b,
    output logic                        o_alu_sub,
    output logic                        o_alu_sign,
    output logic [ALU_T_W-1:0]          o_alu_t,
    input  logic [31:0]                 i_alu_r,
    input  logic [31:0]                 i_alu_add_r,
    input  logic                        i_alu_cmp,
    output logic [1:0]                  o_state
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]            o_grant0_cnt,
    output logic [CNT_W-1:0]            o_grant1_cnt,
    output logic [CNT_W-1:0]            o_conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               rr_ptr;     // requester favoured when both are valid
    logic               id;         // owner of the in-flight op
    logic [31:0]        lat_a;
    logic [31:0]        lat_b;
    logic               lat_sub;
    logic               lat_sign;
    logic [ALU_T_W-1:0] lat_t;
    logic [31:0]        rsp_r_q;
    logic [31:0]        rsp_add_r_q;
    logic               rsp_cmp_q;
    logic               rsp_v0;
    logic               rsp_v1;

    logic idle;
    logic both;
    logic grant1;
    logic acc0;
    logic acc1;
    logic rsp_hs;

    // A lone requester wins regardless of rr_ptr, so there is no idle bubble.
    assign idle   = (state == IDLE);
    assign both   = req0.req_valid & req1.req_valid;
    assign grant1 = both ? rr_ptr : req1.req_valid;

    assign req0.req_ready = idle & ~i_reset & req0.req_valid & ~grant1;
    assign req1.req_ready = idle & ~i_reset & req1.req_valid &  grant1;

    assign acc0   = req0.req_valid & req0.req_ready;
    assign acc1   = req1.req_valid & req1.req_ready;
    assign rsp_hs = id ? (rsp_v1 & req1.rsp_ready) : (rsp_v0 & req0.rsp_ready);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            id          <= 1'b0;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_sub     <= 1'b0;
            lat_sign    <= 1'b0;
            lat_t       <= '0;
            rsp_r_q     <= '0;
            rsp_add_r_q <= '0;
            rsp_cmp_q   <= 1'b0;
            rsp_v0      <= 1'b0;
            rsp_v1      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 | acc1) begin
                        lat_a    <= acc1 ? req1.req_a     : req0.req_a;
                        lat_b    <= acc1 ? req1.req_b     : req0.req_b;
                        lat_sub  <= acc1 ? req1.req_sub   : req0.req_sub;
                        lat_sign <= acc1 ? req1.req_sign  : req0.req_sign;
                        lat_t    <= acc1 ? req1.req_alu_t : req0.req_alu_t;
                        id       <= acc1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_r_q     <= i_alu_r;
                    rsp_add_r_q <= i_alu_add_r;
                    rsp_cmp_q   <= i_alu_cmp;
                    rsp_v0      <= ~id;
                    rsp_v1      <= id;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_v0 <= 1'b0;
                        rsp_v1 <= 1'b0;
                        rr_ptr <= ~id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The ALU always sees the latched operands, never the live request.
    assign o_alu_a    = lat_a;
    assign o_alu_b    = lat_b;
    assign o_alu_sub  = lat_sub;
    assign o_alu_sign = lat_sign;
    assign o_alu_t    = lat_t;
    assign o_state    = state;

    // Response data is one shared register; only valid is per requester.
    assign req0.rsp_valid = rsp_v0;
    assign req1.rsp_valid = rsp_v1;
    assign req0.rsp_r     = rsp_r_q;
    assign req1.rsp_r     = rsp_r_q;
    assign req0.rsp_cmp   = rsp_cmp_q;
    assign req1.rsp_cmp   = rsp_cmp_q;
    assign req0.rsp_add_r = rsp_add_r_q;
    assign req1.rsp_add_r = rsp_add_r_q;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] grant0_cnt;
    logic [CNT_W-1:0] grant1_cnt;
    logic [CNT_W-1:0] conflict_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            grant0_cnt   <= '0;
            grant1_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (acc0)        grant0_cnt   <= grant0_cnt + 1'b1;
            if (acc1)        grant1_cnt   <= grant1_cnt + 1'b1;
            if (idle & both) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign o_grant0_cnt   = grant0_cnt;
    assign o_grant1_cnt   = grant1_cnt;
    assign o_conflict_cnt = conflict_cnt;
`endif

endmodule
